// File: rtl/sram_axi_bridge_if.sv
// Signal bundle between d_cache's sram-like data port, sram_axi_bridge and the AXI4 interconnect.
// The master modport is the bridge's view; slave is the view of the surrounding cache + AXI slave.
interface sram_axi_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Converts one sram-like cache_data_* request at a time into a single-beat AXI4 read or write.
// All AXI valids/readies and data_data_ok come straight from flops; only data_addr_ok is combinational.
module sram_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    sram_axi_bridge_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic        wr_r, wr_s;
    logic [1:0]  size_r, size_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] rdata_r, rdata_s;
    logic        arvalid_r, arvalid_s;
    logic        rready_r, rready_s;
    logic        awvalid_r, awvalid_s;
    logic        wvalid_r, wvalid_s;
    logic        bready_r, bready_s;
    logic        data_ok_r, data_ok_s;
    logic        aw_done_r, aw_done_s;
    logic        w_done_r, w_done_s;
    logic        unused_resp_s;

    // Byte-lane enables; size 3 has no meaning on this port and is widened to a full word.
    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << offset;
            2'd1:    strb = offset[1] ? 4'b1100 : 4'b0011;
            2'd2:    strb = 4'b1111;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // State, latched request and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            wr_r      <= 1'b0;
            size_r    <= 2'd0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            rdata_r   <= 32'd0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            data_ok_r <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            wr_r      <= wr_s;
            size_r    <= size_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            rdata_r   <= rdata_s;
            arvalid_r <= arvalid_s;
            rready_r  <= rready_s;
            awvalid_r <= awvalid_s;
            wvalid_r  <= wvalid_s;
            bready_r  <= bready_s;
            data_ok_r <= data_ok_s;
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_s   = state_r;
        wr_s      = wr_r;
        size_s    = size_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        rdata_s   = rdata_r;
        arvalid_s = arvalid_r;
        rready_s  = rready_r;
        awvalid_s = awvalid_r;
        wvalid_s  = wvalid_r;
        bready_s  = bready_r;
        data_ok_s = 1'b0;
        aw_done_s = aw_done_r;
        w_done_s  = w_done_r;
        case (state_r)
            IDLE: begin
                if (bus.data_req) begin
                    wr_s    = bus.data_wr;
                    size_s  = bus.data_size;
                    addr_s  = bus.data_addr;
                    wdata_s = bus.data_wdata;
                    if (bus.data_wr) begin
                        state_s   = WR_AWW;
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                        aw_done_s = 1'b0;
                        w_done_s  = 1'b0;
                    end else begin
                        state_s   = RD_AR;
                        arvalid_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_AR: begin
                if (bus.arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = RD_R;
                end else begin
                    state_s = RD_AR;
                end
            end
            RD_R: begin
                if (bus.rvalid) begin
                    rready_s  = 1'b0;
                    rdata_s   = wr_r ? rdata_r : bus.rdata;
                    data_ok_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s = RD_R;
                end
            end
            WR_AWW: begin
                // AW and W complete independently; each valid falls after its own handshake.
                aw_done_s = aw_done_r | (awvalid_r & bus.awready);
                w_done_s  = w_done_r | (wvalid_r & bus.wready);
                awvalid_s = awvalid_r & ~bus.awready;
                wvalid_s  = wvalid_r & ~bus.wready;
                if (aw_done_s && w_done_s) begin
                    bready_s = 1'b1;
                    state_s  = WR_B;
                end else begin
                    state_s = WR_AWW;
                end
            end
            WR_B: begin
                if (bus.bvalid) begin
                    bready_s  = 1'b0;
                    data_ok_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s = WR_B;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s   = IDLE;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                bready_s  = 1'b0;
            end
        endcase
    end

    assign bus.data_addr_ok = bus.data_req & (state_r == IDLE);
    assign bus.data_data_ok = data_ok_r;
    assign bus.data_rdata   = rdata_r;

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = addr_r;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = {1'b0, size_r};
    assign bus.arburst = 2'd1;
    assign bus.arvalid = arvalid_r;
    assign bus.rready  = rready_r;

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addr_r;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = {1'b0, size_r};
    assign bus.awburst = 2'd1;
    assign bus.awvalid = awvalid_r;
    assign bus.wdata   = wdata_r;
    assign bus.wstrb   = lane_strobe(size_r, addr_r[1:0]);
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_r;
    assign bus.bready  = bready_r;

    // Response status and rlast carry nothing the cache can act on.
    assign unused_resp_s = ^{bus.rresp, bus.rlast, bus.bresp};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a vector table run through a delay-programmable AXI slave,
// plus hand-written back-to-back and mid-transaction reset sequences.
module tb_sram_axi_bridge;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sram_axi_bridge_if bus ();

    sram_axi_bridge #(.AXI_ID(4'd1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_resp;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        int          ar_dly;
        int          r_dly;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
    } vec_t;

    vec_t tbl [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'd0;
        bus.rresp   = 2'd0;
        bus.rlast   = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'd0;
    endtask

    // Presents a request in an IDLE cycle, expects immediate acceptance, steps to the next cycle.
    task automatic accept(input vec_t v);
        bus.data_req   = 1'b1;
        bus.data_wr    = v.wr;
        bus.data_size  = v.size;
        bus.data_addr  = v.addr;
        bus.data_wdata = v.wdata;
        #1;
        check("addr_ok_accept", 32'(bus.data_addr_ok), 32'd1);
        @(negedge clk);
    endtask

    // Plays the AXI slave for one accepted transaction; returns at the negedge of the next IDLE cycle.
    task automatic service(input vec_t v);
        int  ok_n = 0;
        int  lat = 0;
        int  ar_n = 0;
        int  r_n = 0;
        int  aw_n = 0;
        int  w_n = 0;
        int  b_n = 0;
        int  exp_lat;
        bit  done = 1'b0;
        exp_lat = v.wr ? 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly
                       : 3 + v.ar_dly + v.r_dly;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            if (!bus.data_data_ok && ok_n > 0) begin
                done = 1'b1;
            end else begin
                if (bus.data_req) check("addr_ok_busy", 32'(bus.data_addr_ok), 32'd0);
                if (bus.arvalid) begin
                    check("ar_on_write", 32'(v.wr), 32'd0);
                    check("araddr", bus.araddr, v.addr);
                    check("arsize", 32'(bus.arsize), 32'({1'b0, v.size}));
                    check("ar_fixed", {bus.arid, bus.arlen, bus.arburst}, {4'd1, 8'd0, 2'd1});
                    bus.arready = (ar_n >= v.ar_dly);
                    ar_n++;
                end else begin
                    bus.arready = 1'b0;
                end
                if (bus.rready) begin
                    bus.rvalid = (r_n >= v.r_dly);
                    bus.rdata  = bus.rvalid ? v.rd_resp : ~v.rd_resp;
                    r_n++;
                end else begin
                    bus.rvalid = 1'b0;
                    bus.rdata  = 32'hFFFF_0000;
                end
                if (bus.awvalid) begin
                    check("awaddr", bus.awaddr, v.addr);
                    check("awsize", 32'(bus.awsize), 32'({1'b0, v.size}));
                    check("aw_fixed", {bus.awid, bus.awlen, bus.awburst}, {4'd1, 8'd0, 2'd1});
                    bus.awready = (aw_n >= v.aw_dly);
                    aw_n++;
                end else begin
                    bus.awready = 1'b0;
                end
                if (bus.wvalid) begin
                    check("wdata", bus.wdata, v.wdata);
                    check("wstrb", 32'(bus.wstrb), 32'(v.strb));
                    check("wlast", 32'(bus.wlast), 32'd1);
                    bus.wready = (w_n >= v.w_dly);
                    w_n++;
                end else begin
                    bus.wready = 1'b0;
                end
                if (bus.bready) begin
                    bus.bvalid = (b_n >= v.b_dly);
                    b_n++;
                end else begin
                    bus.bvalid = 1'b0;
                end
                if (bus.data_data_ok) begin
                    ok_n++;
                    lat = cyc;
                    check("data_rdata", bus.data_rdata, v.exp_rdata);
                end
                @(negedge clk);
            end
        end
        check("txn_done", 32'(done), 32'd1);
        check("data_ok_pulses", 32'(ok_n), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("ar_cycles", 32'(ar_n), v.wr ? 32'd0 : 32'(v.ar_dly + 1));
        check("r_cycles", 32'(r_n), v.wr ? 32'd0 : 32'(v.r_dly + 1));
        check("aw_cycles", 32'(aw_n), v.wr ? 32'(v.aw_dly + 1) : 32'd0);
        check("w_cycles", 32'(w_n), v.wr ? 32'(v.w_dly + 1) : 32'd0);
        check("b_cycles", 32'(b_n), v.wr ? 32'(v.b_dly + 1) : 32'd0);
        check("idle_handshakes", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1;
        vec_t v2;
        checks = 0;
        errors = 0;
        //          wr    size  addr           wdata          rd_resp        strb     exp_rdata     ar r aw w b
        tbl[0] = '{1'b0, 2'd2, 32'h1FC0_0010, 32'h0000_0000, 32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF, 0, 0, 0, 0, 0};
        tbl[1] = '{1'b1, 2'd0, 32'h0000_1003, 32'hAA00_0000, 32'h0000_0000, 4'b1000, 32'hDEAD_BEEF, 0, 0, 0, 0, 0};
        tbl[2] = '{1'b1, 2'd2, 32'h8000_0004, 32'h1234_5678, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 0, 0, 3, 0, 0};
        tbl[3] = '{1'b1, 2'd1, 32'h0000_2002, 32'hBEEF_0000, 32'h0000_0000, 4'b1100, 32'hDEAD_BEEF, 0, 0, 0, 0, 5};
        tbl[4] = '{1'b1, 2'd1, 32'h0000_2000, 32'h0000_CAFE, 32'h0000_0000, 4'b0011, 32'hDEAD_BEEF, 0, 0, 0, 2, 0};
        tbl[5] = '{1'b1, 2'd0, 32'h0000_1001, 32'h0000_5500, 32'h0000_0000, 4'b0010, 32'hDEAD_BEEF, 0, 0, 1, 1, 1};
        tbl[6] = '{1'b0, 2'd0, 32'h0000_0010, 32'h0000_0000, 32'h0000_00A5, 4'b0000, 32'h0000_00A5, 2, 3, 0, 0, 0};
        tbl[7] = '{1'b1, 2'd3, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1111, 32'h0000_00A5, 0, 0, 0, 0, 0};
        tbl[8] = '{1'b0, 2'd1, 32'h0000_0002, 32'h0000_0000, 32'h1357_2468, 4'b0000, 32'h1357_2468, 1, 0, 0, 0, 0};
        tbl[9] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_0077, 32'h0000_0000, 4'b0001, 32'h1357_2468, 0, 0, 0, 0, 0};

        rst            = 1'b1;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
        clear_slave();
        repeat (3) @(negedge clk);
        check("reset_handshakes", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        check("reset_data_ok", 32'(bus.data_data_ok), 32'd0);
        check("reset_rdata", bus.data_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            accept(tbl[i]);
            bus.data_req = 1'b0;
            service(tbl[i]);
        end

        // Second request held high through the first: accepted only in the IDLE cycle after data_ok.
        v1 = '{1'b0, 2'd2, 32'h0000_0100, 32'h0000_0000, 32'h0BAD_F00D, 4'b0000, 32'h0BAD_F00D, 0, 0, 0, 0, 0};
        v2 = '{1'b1, 2'd2, 32'h0000_0104, 32'h55AA_55AA, 32'h0000_0000, 4'b1111, 32'h0BAD_F00D, 0, 0, 0, 0, 0};
        accept(v1);
        bus.data_wr    = v2.wr;
        bus.data_size  = v2.size;
        bus.data_addr  = v2.addr;
        bus.data_wdata = v2.wdata;
        service(v1);
        accept(v2);
        bus.data_req = 1'b0;
        service(v2);

        // Reset while waiting for R abandons the read and clears everything.
        v1 = '{1'b0, 2'd2, 32'h0000_0200, 32'h0000_0000, 32'h6666_7777, 4'b0000, 32'h6666_7777, 0, 0, 0, 0, 0};
        accept(v1);
        bus.data_req = 1'b0;
        check("rst_seq_arvalid", 32'(bus.arvalid), 32'd1);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        check("rst_seq_rready", 32'(bus.rready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_handshakes", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        check("rst_mid_data_ok", 32'(bus.data_data_ok), 32'd0);
        check("rst_mid_rdata", bus.data_rdata, 32'd0);
        accept(v1);
        bus.data_req = 1'b0;
        service(v1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
